uart_tx_sequencer: RTL
======================

# uart_tx_sequencer

Byte sequencer for the UART transmit path. It accepts one multi-byte result word, such as a CORDIC logarithm output, with a single start pulse. It then streams the word MSB-first, one byte per transmit cycle, through the buffered UART transmitter (`TX_Start`/`DATAIN`/`TX_Done` handshake). It sits between the computation core and the UART TX wrapper and owns all sequencing of that transmitter.

## Interface

Parameters:
- `NBYTES`, default 4: number of data bytes per word; legal range 1..16.
- `WIDTH`, default 8*NBYTES: word width; derived, not overridden.

Ports:
- `CLK` in 1: single clock; all logic is rising-edge.
- `RST` in 1: reset, synchronous and active-high.
- `start` in 1: request to send `data_in`; sampled only in IDLE.
- `data_in` in WIDTH: word to send; captured on the accepted `start` cycle.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when the last byte's `tx_done` has been consumed.
- `tx_start` out 1: one-cycle pulse to the transmitter `TX_Start`.
- `tx_data` out 8: byte to the transmitter `DATAIN`.
- `tx_done` in 1: transmitter `TX_Done`; one-cycle pulse per byte finished.

## Operation

- The word register `shreg[WIDTH-1:0]` is loaded from `data_in` on an accepted start.
- The byte counter `cnt` has width `$clog2(NBYTES+1)` and counts bytes already launched.
- `tx_data` is always `shreg[WIDTH-1 -: 8]`. It is registered, so it is stable from `tx_start` until the matching `tx_done`.
- State machine (all outputs registered):
  - IDLE: if `start`, load `shreg`, clear `cnt`, go to SEND. Otherwise stay.
  - SEND: assert `tx_start` for this cycle only, increment `cnt`, go to WAIT.
  - WAIT: hold until `tx_done`=1. On `tx_done`:
    - if `cnt` < NBYTES, shift `shreg` left by 8 and go to SEND;
    - else go to CSUM (with `TX_CHECKSUM_EN`) or FIN.
  - CSUM (only with `TX_CHECKSUM_EN`): the checksum byte is presented, then WAIT-like handling of `tx_done`, then FIN.
  - FIN: pulse `done` and return to IDLE. `busy` is 0 in the cycle `done` is 1.
- `start` in any state other than IDLE is ignored; no queuing.
- `tx_done` in IDLE, SEND or FIN is ignored. It is only consumed in WAIT/CSUM.
- `data_in` changes after acceptance have no effect on the word in flight.
- `RST` mid-word aborts immediately. The next cycle is in IDLE with all outputs at their reset values, and the partial word is discarded.
- Reset values: `busy`=0, `done`=0, `tx_start`=0, `tx_data`=8'h00, `shreg`=0, `cnt`=0, state=IDLE.

## Timing

- Cycle 0: `start`=1 in IDLE.
- Cycle 1: SEND; `tx_start`=1, `tx_data`=byte0, `busy`=1.
- Subsequent bytes: `tx_start` rises exactly 2 cycles after the previous byte's `tx_done` cycle (WAIT→SEND, then the SEND pulse). `tx_data` updates 1 cycle after `tx_done`.
- After the final `tx_done` at cycle T: FIN at T+1 with `done`=1 and `busy`=0; IDLE at T+2.
- A `start` at T+1 is not accepted. The earliest accepted `start` is at T+2.
- `tx_start` is never high in two consecutive cycles.
- Total overhead per word: 2 cycles per byte plus 2, excluding UART bit time.

## Configuration

- `TX_CHECKSUM_EN` defined:
  - `csum` is an 8-bit register cleared on accept and XORed with each byte as it is launched.
  - After the last data byte, one extra byte equal to the XOR of all NBYTES data bytes is sent through the CSUM state, with the same `tx_start`/`tx_done` timing as a data byte.
  - `done` follows that byte's `tx_done`.
- `TX_CHECKSUM_EN` undefined: the CSUM state and `csum` register are absent, and exactly NBYTES bytes are sent.

## Test plan

- Reset, then idle for 10 cycles: `busy`=0, `done`=0, `tx_start`=0 and `tx_data`=00 throughout.
- `data_in`=32'hA1B2C3D4 with one-cycle `start`, and the bench answers each `tx_start` with `tx_done` 5 cycles later:
  - bytes A1, B2, C3, D4 each appear with a single `tx_start`;
  - `done` pulses once, 1 cycle after the 4th `tx_done`.
- With `TX_CHECKSUM_EN` and the same word: a 5th byte 8'h04 follows D4, and `done` pulses only after its `tx_done`.
- Protocol robustness:
  - `start` with new data while busy: ignored, and the original bytes are unchanged;
  - `data_in` toggled mid-word: no effect;
  - spurious `tx_done` in IDLE: no `tx_start`.
- Mid-word abort: assert `RST` for 1 cycle after byte B2's `tx_start`. Next cycle all outputs are at reset values. A new `start` with 32'h01020304 then sends 01, 02, 03, 04 correctly.
- Back-to-back words: `start` held high continuously, answered with `tx_done` 1 cycle after each `tx_start`. The second word is accepted exactly 2 cycles after the final `tx_done` of the first word.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: streams one NBYTES-wide word MSB-first through a TX_Start/DATAIN/TX_Done byte transmitter.
// Latency: first tx_start 1 cycle after an accepted start, later bytes 2 cycles after tx_done, done 1 cycle after the final tx_done.
// Backpressure: start is ignored while busy (no queuing); each byte waits indefinitely for tx_done.
// Build option: define TX_CHECKSUM_EN to append one XOR checksum byte after the data bytes.
module uart_tx_sequencer #(
  parameter int NBYTES = 4,
  parameter int WIDTH  = 8 * NBYTES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_done
);

  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES);

`ifdef TX_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_CSUM, S_FIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_FIN} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             tx_start_nxt;
  logic             load;
  logic             shift;
  logic             launch;
`ifdef TX_CHECKSUM_EN
  logic [7:0]       csum;
  logic             launched;
  logic             csum_load;
  logic             csum_fire;
`endif

  // The byte on the wire is always the top byte of the word register.
  assign tx_data = shreg[WIDTH-1 -: 8];

  // State register and registered handshake/status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_start <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != S_IDLE) && (state_nxt != S_FIN);
      done     <= (state_nxt == S_FIN);
      tx_start <= tx_start_nxt;
    end
  end

  // Next-state logic; SEND holds one extra cycle when entered from WAIT so the new byte settles before tx_start.
  always_comb begin
    state_nxt    = state;
    tx_start_nxt = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    launch       = 1'b0;
`ifdef TX_CHECKSUM_EN
    csum_load    = 1'b0;
    csum_fire    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          load         = 1'b1;
          tx_start_nxt = 1'b1;
          state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_start) begin
          launch    = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          tx_start_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          if (cnt < LAST) begin
            shift     = 1'b1;
            state_nxt = S_SEND;
          end else begin
`ifdef TX_CHECKSUM_EN
            csum_load = 1'b1;
            state_nxt = S_CSUM;
`else
            state_nxt = S_FIN;
`endif
          end
        end
      end
`ifdef TX_CHECKSUM_EN
      S_CSUM: begin
        if (!launched) begin
          if (tx_start) begin
            csum_fire = 1'b1;
          end else begin
            tx_start_nxt = 1'b1;
          end
        end else if (tx_done) begin
          state_nxt = S_FIN;
        end
      end
`endif
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Word register, launched-byte counter and optional running checksum.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg    <= '0;
      cnt      <= '0;
`ifdef TX_CHECKSUM_EN
      csum     <= 8'h00;
      launched <= 1'b0;
`endif
    end else begin
      if (load) begin
        shreg <= data_in;
        cnt   <= '0;
`ifdef TX_CHECKSUM_EN
        csum  <= 8'h00;
`endif
      end
      if (shift) begin
        shreg <= shreg << 8;
      end
      if (launch) begin
        cnt  <= cnt + CW'(1);
`ifdef TX_CHECKSUM_EN
        csum <= csum ^ tx_data;
`endif
      end
`ifdef TX_CHECKSUM_EN
      if (csum_load) begin
        shreg[WIDTH-1 -: 8] <= csum;
        launched            <= 1'b0;
      end
      if (csum_fire) begin
        launched <= 1'b1;
      end
`endif
    end
  end

endmodule
